// File: rtl/spi_sensor_emu.sv
// ---------------------------------------------------------------------------
// spi_sensor_emu
//
// FPGA-side SPI responder that behaves like the board accelerometer's
// register interface (4-wire, SPI mode 3, 8-bit command byte followed by
// data bytes). Used for loopback bring-up and for exercising the sensor
// driver without the physical part fitted.
//
// Command byte: bit7 = read (1) / write (0), bit6 = auto-increment,
// bits5:0 = register address.
//
// Ports:
//   clk          system clock, at least 8x the SCK frequency
//   reset        asynchronous, active-low reset
//   spi_sck      SPI clock from the master, idles high
//   spi_csn      SPI chip select, active-low
//   spi_mosi     master-to-slave data
//   spi_miso     slave-to-master data
//   spi_miso_oe  tristate enable for spi_miso, high only while selected
//   host_we      host write strobe
//   host_addr    host register address
//   host_wdata   host write data
//   host_rdata   registered read of mem[host_addr]
//   wr_strobe    one-clk pulse when an SPI write commits
//   wr_addr      address of the last SPI-committed write
//   frame_done   one-clk pulse when a frame that got past the command ends
// ---------------------------------------------------------------------------
module spi_sensor_emu #(
    parameter logic [5:0] WHOAMI_ADDR = 6'h0F,
    parameter logic [7:0] WHOAMI_VAL  = 8'h33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_sck,
    input  logic       spi_csn,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic       host_we,
    input  logic [5:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic [7:0] host_rdata,
    output logic       wr_strobe,
    output logic [5:0] wr_addr,
    output logic       frame_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    // Synchronizer chains; index 0 is the flop nearest the pin.
    logic [2:0] sck_sync_q;
    logic [2:0] csn_sync_q;
    logic [1:0] mosi_sync_q;

    logic       sck_rise;
    logic       sck_fall;
    logic       csn_s;
    logic       csn_fall;
    logic       mosi_s;

    logic [1:0] state_q, state_d;
    logic [2:0] bit_q, bit_d;
    logic [6:0] rx_q, rx_d;
    logic [6:0] tx_q, tx_d;
    logic       miso_q, miso_d;
    logic       rw_q, rw_d;
    logic       ms_q, ms_d;
    logic [5:0] addr_q, addr_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic [5:0] wr_addr_q, wr_addr_d;
    logic       frame_done_q, frame_done_d;
    logic [7:0] host_rdata_q;

    logic [7:0] mem_q [64];

    logic [7:0] rx_byte;
    logic [7:0] rd_byte;
    logic       spi_we;

    // The SCK chain resets high (its idle level) so that releasing reset
    // with SCK idle produces no phantom edge. The CSN chain resets low: if
    // reset is released while CSN is already low, no falling edge is seen
    // and the interrupted frame is ignored until CSN goes high and low again.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_sync_q  <= 3'b111;
            csn_sync_q  <= 3'b000;
            mosi_sync_q <= 2'b00;
        end else begin
            sck_sync_q  <= {sck_sync_q[1:0], spi_sck};
            csn_sync_q  <= {csn_sync_q[1:0], spi_csn};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
        end
    end

    assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
    assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
    assign csn_s    = csn_sync_q[1];
    assign csn_fall = ~csn_sync_q[1] & csn_sync_q[2];
    assign mosi_s   = mosi_sync_q[1];

    // Byte being assembled including the bit arriving on this rising edge.
    assign rx_byte = {rx_q, mosi_s};
    assign rd_byte = mem_q[addr_q];

    // Frame FSM. A high CSN overrides every SCK event so a partial byte is
    // simply dropped. Reads present data on falling edges so the master
    // sees it stable on the following rising edge.
    always_comb begin
        state_d      = state_q;
        bit_d        = bit_q;
        rx_d         = rx_q;
        tx_d         = tx_q;
        miso_d       = miso_q;
        rw_d         = rw_q;
        ms_d         = ms_q;
        addr_d       = addr_q;
        wr_strobe_d  = 1'b0;
        wr_addr_d    = wr_addr_q;
        frame_done_d = 1'b0;
        spi_we       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (csn_fall) begin
                    state_d = ST_CMD;
                    bit_d   = 3'd0;
                end
            end

            ST_CMD: begin
                miso_d = 1'b0;
                if (csn_s) begin
                    state_d = ST_IDLE;
                end else if (sck_rise) begin
                    rx_d  = rx_byte[6:0];
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        rw_d    = rx_byte[7];
                        ms_d    = rx_byte[6];
                        addr_d  = rx_byte[5:0];
                        state_d = ST_DATA;
                        bit_d   = 3'd0;
                    end
                end
            end

            ST_DATA: begin
                if (csn_s) begin
                    state_d      = ST_IDLE;
                    miso_d       = 1'b0;
                    frame_done_d = 1'b1;
                end else begin
                    if (sck_fall && rw_q) begin
                        if (bit_q == 3'd0) begin
                            tx_d   = rd_byte[6:0];
                            miso_d = rd_byte[7];
                        end else begin
                            tx_d   = {tx_q[5:0], 1'b0};
                            miso_d = tx_q[6];
                        end
                    end
                    if (sck_rise) begin
                        rx_d  = rx_byte[6:0];
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            bit_d = 3'd0;
                            if (!rw_q) begin
                                spi_we      = 1'b1;
                                wr_strobe_d = 1'b1;
                                wr_addr_d   = addr_q;
                            end
                            if (ms_q) begin
                                addr_d = addr_q + 6'd1;
                            end
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                miso_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            bit_q        <= 3'd0;
            rx_q         <= 7'd0;
            tx_q         <= 7'd0;
            miso_q       <= 1'b0;
            rw_q         <= 1'b0;
            ms_q         <= 1'b0;
            addr_q       <= 6'd0;
            wr_strobe_q  <= 1'b0;
            wr_addr_q    <= 6'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_q        <= bit_d;
            rx_q         <= rx_d;
            tx_q         <= tx_d;
            miso_q       <= miso_d;
            rw_q         <= rw_d;
            ms_q         <= ms_d;
            addr_q       <= addr_d;
            wr_strobe_q  <= wr_strobe_d;
            wr_addr_q    <= wr_addr_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Register file. The identification register is constant; an SPI commit
    // takes priority over a host write to the same address, while host
    // writes to other addresses land in the same clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++) begin
                mem_q[i] <= (6'(i) == WHOAMI_ADDR) ? WHOAMI_VAL : 8'h00;
            end
        end else begin
            for (int i = 0; i < 64; i++) begin
                if (6'(i) != WHOAMI_ADDR) begin
                    if (spi_we && (addr_q == 6'(i))) begin
                        mem_q[i] <= rx_byte;
                    end else if (host_we && (host_addr == 6'(i))) begin
                        mem_q[i] <= host_wdata;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            host_rdata_q <= 8'h00;
        end else begin
            host_rdata_q <= mem_q[host_addr];
        end
    end

    // The enable tracks the selected frame only; a frame interrupted by
    // reset keeps the pin released even though CSN is still low.
    assign spi_miso_oe = (state_q != ST_IDLE) & ~csn_s;
    assign spi_miso    = miso_q;
    assign host_rdata  = host_rdata_q;
    assign wr_strobe   = wr_strobe_q;
    assign wr_addr     = wr_addr_q;
    assign frame_done  = frame_done_q;

endmodule
